// File: rtl/csr_mem_arbiter.sv
// csr_mem_arbiter: 2:1 round-robin Wishbone classic arbiter in front of csr_mem
// (msip/mtime/mtimecmp). Primary 0 is the core load/store port, primary 1 the debug module.
// The grant is registered and is held while the granted primary keeps cyc high. The granted
// primary is forwarded to the slave combinationally.
// Optional watchdog: define CSR_ARB_TIMEOUT_EN to error out stalled transactions after
// TIMEOUT_CYCLES-1 stalled strobe cycles.
module csr_mem_arbiter #(
  parameter int DATA_SIZE      = 32,
  parameter int ADDR_SIZE      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 p0_cyc,
  input  logic                 p0_stb,
  input  logic                 p0_we,
  input  logic [ADDR_SIZE-1:0] p0_addr,
  input  logic [DATA_SIZE-1:0] p0_dat,
  output logic                 p0_ack,
  output logic                 p0_err,
  input  logic                 p1_cyc,
  input  logic                 p1_stb,
  input  logic                 p1_we,
  input  logic [ADDR_SIZE-1:0] p1_addr,
  input  logic [DATA_SIZE-1:0] p1_dat,
  output logic                 p1_ack,
  output logic                 p1_err,
  output logic [DATA_SIZE-1:0] p_rd_dat,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADDR_SIZE-1:0] s_addr,
  output logic [DATA_SIZE-1:0] s_dat_o,
  input  logic                 s_ack,
  input  logic [DATA_SIZE-1:0] s_dat_i
);

  // state   | meaning
  // IDLE    | no grant, slave port quiet, s_ack ignored
  // GNT0    | primary 0 owns the slave until p0_cyc drops
  // GNT1    | primary 1 owns the slave until p1_cyc drops
  typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("csr_mem_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   gnt0, gnt1, gnt_any;
  logic   sel_cyc, sel_stb, sel_we;
  logic   stb_raw;
  logic   req0, req1;
  logic   tmo;

  assign gnt0    = (state_q == ST_GNT0);
  assign gnt1    = (state_q == ST_GNT1);
  assign gnt_any = gnt0 | gnt1;
  assign sel_cyc = gnt0 ? p0_cyc : p1_cyc;
  assign sel_stb = gnt0 ? p0_stb : p1_stb;
  assign sel_we  = gnt0 ? p0_we  : p1_we;
  assign stb_raw = gnt_any & sel_cyc & sel_stb;

`ifdef CSR_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT_CYCLES - 1);

  // wd_q counts down the stall cycles still allowed; zero means the limit is reached.
  logic [CW-1:0] wd_q, wd_d;
  // blk_q: a primary that timed out stays out of arbitration until it is seen idle in IDLE.
  logic [1:0]    blk_q, blk_d;

  assign tmo  = stb_raw & (wd_q == '0);
  assign req0 = p0_cyc & ~blk_q[0];
  assign req1 = p1_cyc & ~blk_q[1];

  // Watchdog reload/decrement and block-bit maintenance.
  always_comb begin
    wd_d  = wd_q;
    blk_d = blk_q;
    if ((state_d != state_q) || s_ack || !gnt_any) begin
      wd_d = WD_LOAD;
    end else if (s_stb && (wd_q != '0)) begin
      wd_d = wd_q - CW'(1);
    end
    if (tmo) begin
      blk_d[gnt1 ? 1 : 0] = 1'b1;
    end
    if (state_q == ST_IDLE) begin
      if (!p0_cyc) blk_d[0] = 1'b0;
      if (!p1_cyc) blk_d[1] = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= WD_LOAD;
      blk_q <= 2'b00;
    end else begin
      wd_q  <= wd_d;
      blk_q <= blk_d;
    end
  end
`else
  assign tmo  = 1'b0;
  assign req0 = p0_cyc;
  assign req1 = p1_cyc;
`endif

  // Grant next-state: round-robin from IDLE, direct handoff when the owner releases.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          if (last_q) begin
            state_d = ST_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_GNT1;
            last_d  = 1'b1;
          end
        end else if (req0) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_GNT0: begin
        if (tmo) begin
          state_d = ST_IDLE;
        end else if (!p0_cyc) begin
          if (req1) begin
            state_d = ST_GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GNT1: begin
        if (tmo) begin
          state_d = ST_IDLE;
        end else if (!p1_cyc) begin
          if (req0) begin
            state_d = ST_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant FSM registers; last=1 after reset so primary 0 wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign s_cyc    = gnt_any & sel_cyc & ~tmo;
  assign s_stb    = stb_raw & ~tmo;
  assign s_we     = gnt_any & sel_we;
  assign s_addr   = gnt0 ? p0_addr : (gnt1 ? p1_addr : '0);
  assign s_dat_o  = gnt0 ? p0_dat  : (gnt1 ? p1_dat  : '0);
  assign p0_ack   = s_ack & gnt0 & ~tmo;
  assign p1_ack   = s_ack & gnt1 & ~tmo;
  assign p0_err   = tmo & gnt0;
  assign p1_err   = tmo & gnt1;
  assign p_rd_dat = s_dat_i;

endmodule

// File: tb/tb_csr_mem_arbiter.sv
// Bench for csr_mem_arbiter: directed sequences plus random traffic, checked by a
// scoreboard fed from a behavioural model of the grant rules.
module tb_csr_mem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int TMO = 16;
`ifdef CSR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]         cyc;
    logic [1:0]         stb;
    logic [1:0]         we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] dat;
    logic               sack;
    logic [DW-1:0]      sdat;
  } stim_t;

  typedef struct packed {
    int            cyc;
    logic          scyc;
    logic          sstb;
    logic          swe;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdato;
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] rd;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  stim_t cur = '0;

  logic          p0_cyc, p0_stb, p0_we, p1_cyc, p1_stb, p1_we;
  logic [AW-1:0] p0_addr, p1_addr, s_addr;
  logic [DW-1:0] p0_dat, p1_dat, s_dat_o, s_dat_i, p_rd_dat;
  logic          p0_ack, p0_err, p1_ack, p1_err, s_cyc, s_stb, s_we, s_ack;

  assign p0_cyc  = cur.cyc[0];
  assign p1_cyc  = cur.cyc[1];
  assign p0_stb  = cur.stb[0];
  assign p1_stb  = cur.stb[1];
  assign p0_we   = cur.we[0];
  assign p1_we   = cur.we[1];
  assign p0_addr = cur.addr[0];
  assign p1_addr = cur.addr[1];
  assign p0_dat  = cur.dat[0];
  assign p1_dat  = cur.dat[1];
  assign s_ack   = cur.sack;
  assign s_dat_i = cur.sdat;

  csr_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_cyc(p0_cyc), .p0_stb(p0_stb), .p0_we(p0_we), .p0_addr(p0_addr), .p0_dat(p0_dat),
    .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_cyc(p1_cyc), .p1_stb(p1_stb), .p1_we(p1_we), .p1_addr(p1_addr), .p1_dat(p1_dat),
    .p1_ack(p1_ack), .p1_err(p1_err),
    .p_rd_dat(p_rd_dat),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dat_o(s_dat_o),
    .s_ack(s_ack), .s_dat_i(s_dat_i)
  );

  always #5 clock = ~clock;

  int cyc_n = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad = 0;
  exp_t sbq[$];

  // Reference model: owner -1 = nobody, else primary index; cnt = stalled strobe cycles.
  int         owner = -1;
  int         last = 1;
  int         cnt = 0;
  logic [1:0] blk = 2'b00;

  function automatic void calc(input stim_t s, output exp_t e, output logic tmo);
    int o;
    e   = '0;
    tmo = 1'b0;
    e.rd = s.sdat;
    if (owner >= 0) begin
      o       = owner;
      e.scyc  = s.cyc[o];
      e.sstb  = s.cyc[o] & s.stb[o];
      e.swe   = s.we[o];
      e.saddr = s.addr[o];
      e.sdato = s.dat[o];
      if (TO_EN && e.sstb && (cnt == TMO - 1)) begin
        tmo    = 1'b1;
        e.scyc = 1'b0;
        e.sstb = 1'b0;
        e.err[o] = 1'b1;
      end else begin
        e.ack[o] = s.sack;
      end
    end
  endfunction

  task automatic model_step();
    exp_t       e;
    logic       tmo;
    int         prev;
    logic [1:0] req;
    calc(cur, e, tmo);
    prev = owner;
    req  = cur.cyc & ~blk;
    if (tmo) begin
      blk[owner] = 1'b1;
      owner = -1;
    end else if (owner < 0) begin
      if (req == 2'b11) owner = 1 - last;
      else if (req[0]) owner = 0;
      else if (req[1]) owner = 1;
      if (owner >= 0) last = owner;
    end else if (!cur.cyc[owner]) begin
      if (req[1 - owner]) begin
        owner = 1 - owner;
        last  = owner;
      end else begin
        owner = -1;
      end
    end
    if (prev < 0) blk = blk & cur.cyc;
    if ((owner != prev) || cur.sack || (prev < 0)) cnt = 0;
    else if (e.sstb && (cnt < TMO - 1)) cnt++;
  endtask

  function automatic logic active(input exp_t e);
    return e.scyc | e.sstb | e.swe | (e.saddr != '0) | (e.sdato != '0) | (|e.ack) | (|e.err);
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic tmo;
    @(posedge clock);
    model_step();
    #1;
    cur = s;
    calc(cur, e, tmo);
    e.cyc = cyc_n;
    if (active(e)) sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    cur = '0;
    cur.cyc = 2'b11;
    cur.stb = 2'b11;
    cur.sack = 1'b1;
    owner = -1; last = 1; cnt = 0; blk = 2'b00;
    #2;
    total++;
    if ({s_cyc, s_stb, s_we, s_addr != '0, s_dat_o != '0, p0_ack, p1_ack, p0_err, p1_err} != '0) begin
      bad++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b addr=%h dat=%h ack=%b%b err=%b%b, want all 0",
               s_cyc, s_stb, s_we, s_addr, s_dat_o, p1_ack, p0_ack, p1_err, p0_err);
    end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic stim_t mk(input logic [1:0] c, input logic [1:0] st, input logic [1:0] w,
                               input logic sa, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    stim_t s;
    s = '0;
    s.cyc = c; s.stb = st; s.we = w; s.sack = sa;
    s.addr[0] = a0; s.addr[1] = a1; s.dat[0] = d0; s.dat[1] = d1;
    s.sdat = 32'h5a00_0000 | DW'(cyc_n);
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = cur;
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(3) == 0) s.cyc[i] = ~s.cyc[i];
      s.stb[i]  = 1'($urandom_range(1));
      s.we[i]   = 1'($urandom_range(1));
      s.addr[i] = AW'($urandom);
      s.dat[i]  = $urandom;
    end
    s.sack = 1'($urandom_range(1));
    s.sdat = $urandom;
    return s;
  endfunction

  // Monitor: whenever the DUT drives anything on the slave side or an ack/err, pop and compare.
  exp_t mon_e, mon_g;
  logic present;
  always @(negedge clock) begin
    present = s_cyc | s_stb | s_we | (s_addr != '0) | (s_dat_o != '0) | p0_ack | p1_ack | p0_err | p1_err;
    while (sbq.size() > 0 && sbq[0].cyc < cyc_n) begin
      mon_e = sbq.pop_front();
      total++; bad++;
      $display("FAIL missed_cycle: got no output at cycle %0d, want expected event", mon_e.cyc);
    end
    mon_g = '0;
    mon_g.scyc = s_cyc; mon_g.sstb = s_stb; mon_g.swe = s_we; mon_g.saddr = s_addr;
    mon_g.sdato = s_dat_o; mon_g.ack = {p1_ack, p0_ack}; mon_g.err = {p1_err, p0_err};
    mon_g.rd = p_rd_dat;
    if (present) begin
      total++;
      if (sbq.size() > 0 && sbq[0].cyc == cyc_n) begin
        mon_e = sbq.pop_front();
        mon_g.cyc = mon_e.cyc;
        if (mon_g != mon_e) begin
          bad++;
          $display("FAIL cycle_%0d: got cyc=%b stb=%b we=%b addr=%h dat=%h ack=%b err=%b rd=%h, want cyc=%b stb=%b we=%b addr=%h dat=%h ack=%b err=%b rd=%h",
                   cyc_n, mon_g.scyc, mon_g.sstb, mon_g.swe, mon_g.saddr, mon_g.sdato, mon_g.ack, mon_g.err, mon_g.rd,
                   mon_e.scyc, mon_e.sstb, mon_e.swe, mon_e.saddr, mon_e.sdato, mon_e.ack, mon_e.err, mon_e.rd);
        end
      end else begin
        bad++;
        $display("FAIL unexpected_cycle_%0d: got cyc=%b stb=%b we=%b addr=%h ack=%b err=%b, want idle outputs",
                 cyc_n, s_cyc, s_stb, s_we, s_addr, mon_g.ack, mon_g.err);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc == cyc_n) begin
      mon_e = sbq.pop_front();
      total++; bad++;
      $display("FAIL silent_cycle_%0d: got idle outputs, want cyc=%b stb=%b addr=%h ack=%b err=%b",
               cyc_n, mon_e.scyc, mon_e.sstb, mon_e.saddr, mon_e.ack, mon_e.err);
    end
  end

  initial begin
    do_reset();
    // Tie with both requesting: grants alternate 0,1,0,1 with direct handoff.
    for (int r = 0; r < 2; r++) begin
      step(mk(2'b11, 2'b11, 2'b11, 1'b1, 3'd0, 3'd4, 32'h1, 32'h2));
      step(mk(2'b10, 2'b11, 2'b11, 1'b0, 3'd0, 3'd4, 32'h1, 32'h2));
      step(mk(2'b11, 2'b11, 2'b11, 1'b1, 3'd0, 3'd4, 32'h1, 32'h2));
      step(mk(2'b01, 2'b11, 2'b11, 1'b0, 3'd0, 3'd4, 32'h1, 32'h2));
    end
    step(mk(2'b00, 2'b00, 2'b00, 1'b1, 3'd0, 3'd0, 32'h0, 32'h0));
    step(mk(2'b00, 2'b00, 2'b00, 1'b1, 3'd0, 3'd0, 32'h0, 32'h0));
    // Single p0 write of msip.
    step(mk(2'b01, 2'b01, 2'b01, 1'b1, 3'd0, 3'd0, 32'h1, 32'h0));
    step(mk(2'b01, 2'b01, 2'b01, 1'b1, 3'd0, 3'd0, 32'h1, 32'h0));
    step(mk(2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0));
    // p1 holds cyc over three strobes while p0 waits, then p0 takes over.
    step(mk(2'b10, 2'b10, 2'b00, 1'b0, 3'd0, 3'd1, 32'h0, 32'h0));
    step(mk(2'b11, 2'b11, 2'b00, 1'b1, 3'd2, 3'd1, 32'h7, 32'h0));
    step(mk(2'b11, 2'b11, 2'b00, 1'b1, 3'd2, 3'd2, 32'h7, 32'h0));
    step(mk(2'b11, 2'b11, 2'b10, 1'b1, 3'd2, 3'd3, 32'h7, 32'hcafe));
    step(mk(2'b01, 2'b01, 2'b00, 1'b1, 3'd2, 3'd0, 32'h7, 32'h0));
    step(mk(2'b01, 2'b01, 2'b01, 1'b1, 3'd2, 3'd0, 32'h7, 32'h0));
    step(mk(2'b00, 2'b00, 2'b00, 1'b1, 3'd0, 3'd0, 32'h0, 32'h0));
    // Stalled slave with p1 pending.
    repeat (3) step(mk(2'b01, 2'b01, 2'b01, 1'b0, 3'd3, 3'd0, 32'h9, 32'h0));
    repeat (20) step(mk(2'b11, 2'b11, 2'b01, 1'b0, 3'd3, 3'd5, 32'h9, 32'h3));
    repeat (3) step(mk(2'b10, 2'b10, 2'b00, 1'b1, 3'd0, 3'd5, 32'h0, 32'h3));
    repeat (2) step(mk(2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0));
    // Random traffic with occasional mid-transaction resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else step(rnd());
    end
    repeat (3) step(mk(2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0));
    @(negedge clock);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unmatched expected events, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
